// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU definitions used by the hazard/stall controller.
`default_nettype none
package hazard_stall_ctrl_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_HALT    = 2'd2;

  localparam logic [15:0] NOP_INSTR = 16'b0000100000000000;

  // No R0 exemption: R0 is a real, writable register.
  function automatic logic load_use_hit(
    input logic       ex_memread,
    input logic [2:0] ex_rd,
    input logic       uses_rs,
    input logic [2:0] rs,
    input logic       uses_rt,
    input logic [2:0] rt
  );
    return ex_memread & ((uses_rs & (rs == ex_rd)) | (uses_rt & (rt == ex_rd)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter16.sv
// 16-bit counter that sticks at all-ones; hold freezes it.
`default_nettype none
module sat_counter16
  import hazard_stall_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !hold && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: per-stage hold and bubble decisions for the 5-stage core.
`default_nettype none
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [2:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_stall,
  input  logic             wb_halt,
  output logic             pc_we,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int unsigned          WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic              redirect_inc;
  logic              load_use;

  assign load_use = load_use_hit(ex_memread, ex_rd, id_uses_rs, id_rs, id_uses_rt, id_rt);

  always_comb begin
    pc_we        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_flush  = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    halted_d     = halted_q;
    err_d        = err_q;
    redirect_inc = 1'b0;

    if (state_q == ST_HALT) begin
      pc_we    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (wb_halt) begin
      // Freeze everything upstream of the retiring HALT.
      pc_we    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      state_d  = ST_HALT;
      halted_d = 1'b1;
      wait_d   = '0;
    end else if (dmem_stall) begin
      pc_we       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_d     = ST_MEMWAIT;
      if (state_q == ST_RUN) begin
        wait_d = WAIT_W'(1);
      end else if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + 1'b1;
      end
      if (wait_d == WAIT_MAX) begin
        err_d = 1'b1;
      end
    end else begin
      state_d = ST_RUN;
      wait_d  = '0;
      if (branch_taken) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        redirect_inc = 1'b1;
      end else if (load_use) begin
        pc_we      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      wait_q   <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign halted = halted_q;
  assign err    = err_q;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_we & ~halted_q),
    .hold  (halted_q),
    .count (stall_cnt)
  );

  sat_counter16 u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_inc),
    .hold  (halted_q),
    .count (redirect_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (instance built with MEM_TIMEOUT=3).
`default_nettype none
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_memread;
  logic        branch_taken, dmem_stall, wb_halt;
  logic        pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
  logic        halted, err;
  logic [15:0] stall_cnt, redirect_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  localparam logic [6:0] C_NORMAL = 7'b1101010;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;
  localparam logic [6:0] C_REDIR  = 7'b1111110;
  localparam logic [6:0] C_MWAIT  = 7'b0000001;
  localparam logic [6:0] C_FROZEN = 7'b0000000;

  hazard_stall_ctrl #(.MEM_TIMEOUT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .dmem_stall   (dmem_stall),
    .wb_halt      (wb_halt),
    .pc_we        (pc_we),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .memwb_flush  (memwb_flush),
    .halted       (halted),
    .err          (err),
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  wire [6:0] ctrl = {pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; combinational outputs are sampled at +4.
  task automatic drive(input logic ld, input logic [2:0] rd, input logic urs, input logic [2:0] rs,
                       input logic urt, input logic [2:0] rt, input logic br, input logic ds,
                       input logic wh);
    ex_memread = ld; ex_rd = rd; id_uses_rs = urs; id_rs = rs;
    id_uses_rt = urt; id_rt = rt; branch_taken = br; dmem_stall = ds; wb_halt = wh;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    idle();
    chk("reset_ctrl", 32'(ctrl), 32'(C_NORMAL));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_redir_cnt", 32'(redirect_cnt), 32'd0);
    tick();

    // Load to R3 in EX, ID reads rs=R3: single-cycle stall.
    drive(1, 3'd3, 1, 3'd3, 0, 3'd0, 0, 0, 0);
    chk("lduse_rs_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    idle();
    chk("lduse_after_ctrl", 32'(ctrl), 32'(C_NORMAL));
    chk("lduse_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // rt match with ex_rd = R0 still stalls.
    drive(1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 0, 0);
    chk("lduse_rt_r0_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    // Matching field but not used, or not a load: no stall.
    drive(1, 3'd4, 0, 3'd4, 1, 3'd2, 0, 0, 0);
    chk("nouse_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    drive(0, 3'd4, 1, 3'd4, 0, 3'd0, 0, 0, 0);
    chk("noload_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    chk("stall_cnt_2", 32'(stall_cnt), 32'd2);

    // Redirect beats load-use.
    drive(1, 3'd3, 1, 3'd3, 0, 3'd0, 1, 0, 0);
    chk("redir_over_lduse", 32'(ctrl), 32'(C_REDIR));
    tick();
    idle();
    chk("redir_cnt_1", 32'(redirect_cnt), 32'd1);
    chk("redir_no_stall", 32'(stall_cnt), 32'd2);

    // 4-cycle memory wait with branch pending, then the redirect.
    for (int i = 0; i < 4; i++) begin
      drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0);
      chk($sformatf("mwait_ctrl_%0d", i), 32'(ctrl), 32'(C_MWAIT));
      tick();
    end
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0);
    chk("mwait_then_redir", 32'(ctrl), 32'(C_REDIR));
    tick();
    idle();
    chk("mwait_stall_cnt", 32'(stall_cnt), 32'd6);
    chk("mwait_redir_cnt", 32'(redirect_cnt), 32'd2);

    // Timeout: err rises after the 3rd consecutive stall cycle and stays set.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0);
      tick();
      if (i == 2) chk("err_after_2", 32'(err), 32'd0);
      if (i == 3) chk("err_after_3", 32'(err), 32'd1);
    end
    idle();
    chk("err_sticky_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    chk("timeout_stall_cnt", 32'(stall_cnt), 32'd5);

    // Reset in the middle of a wait.
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0);
    tick();
    do_reset();
    idle();
    chk("rst_mwait_ctrl", 32'(ctrl), 32'(C_NORMAL));
    chk("rst_mwait_err", 32'(err), 32'd0);

    // One redirect, then HALT; later inputs are ignored.
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0);
    tick();
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    chk("halt_cycle_ctrl", 32'(ctrl), 32'(C_FROZEN));
    tick();
    idle();
    chk("halted_set", 32'(halted), 32'd1);
    chk("halted_ctrl", 32'(ctrl), 32'(C_FROZEN));
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd1, 1, 3'd1, 0, 3'd0, 1, (i == 1), 0);
      chk($sformatf("halted_ign_%0d", i), 32'(ctrl), 32'(C_FROZEN));
      tick();
    end
    chk("halted_redir_frozen", 32'(redirect_cnt), 32'd1);
    chk("halted_stall_frozen", 32'(stall_cnt), 32'd1);
    chk("halted_sticky", 32'(halted), 32'd1);
    do_reset();
    idle();
    chk("unhalt_halted", 32'(halted), 32'd0);
    chk("unhalt_ctrl", 32'(ctrl), 32'(C_NORMAL));
    chk("unhalt_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("unhalt_redir_cnt", 32'(redirect_cnt), 32'd0);

    // Saturation: 65537 load-use stall cycles.
    drive(1, 3'd6, 1, 3'd6, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
    idle();
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
